syn_fifo: RTL and testbench

Synchronous single-bit FIFO with an integrated BPSK symbol mapper for the digital-modulation datapath. The upstream bit source writes serial data bits. The modulator back-end reads them out one at a time. Each accepted read also produces a signed 16-bit constellation point (±AMP) on data_pt for the DAC/pulse-shaping stage.

---
 rtl/syn_fifo_pkg.sv | 16 +
 rtl/bpsk_mapper.sv | 27 ++
 rtl/syn_fifo.sv | 88 ++++++++
 tb/tb_syn_fifo.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/syn_fifo_pkg.sv
// Shared definitions for the syn_fifo bit FIFO and its BPSK mapper:
// default sizing, the pointer-width helper and the signed sample type.
package syn_fifo_pkg;

   localparam int DEFAULT_DEPTH = 8;
   localparam int DEFAULT_AMP   = 16383;

   // Signed constellation sample handed to the DAC / pulse-shaping stage.
   typedef logic signed [15:0] sample_t;

   // Pointer width: index bits plus one wrap bit that separates full from empty.
   function automatic int ptr_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/bpsk_mapper.sv
// BPSK symbol mapper: on load, registers +AMP for bit 1 or -AMP for bit 0,
// and holds that point until the next load. Reset clears the point to 0.
module bpsk_mapper
   import syn_fifo_pkg::*;
#(
   parameter int AMP = DEFAULT_AMP
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    load,
   input  logic    data_bit,
   output sample_t point
);

   localparam sample_t POS_PT = sample_t'(AMP);
   localparam sample_t NEG_PT = -POS_PT;

   // Register the constellation point of each loaded bit; hold otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         point <= '0;
      end else if (load) begin
         point <= data_bit ? POS_PT : NEG_PT;
      end
   end

endmodule

// File: rtl/syn_fifo.sv
// syn_fifo: synchronous single-bit FIFO with an optional BPSK mapper on the
// read side. Define SYN_FIFO_MAPPER_EN to build the mapper; without it
// data_pt is a constant zero and everything else is unchanged.
// Pointers carry one wrap bit: equal pointers mean empty, equal index bits
// with differing wrap bits mean full. Flags depend on registered pointers only.
module syn_fifo
   import syn_fifo_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int AMP   = DEFAULT_AMP
) (
   input  logic    CLK,
   input  logic    RST,
   input  logic    wEN,
   input  logic    rEN,
   input  logic    dIn,
   output logic    bFull,
   output logic    bEmpty,
   output logic    dOut,
   output logic    dFLAG,
   output sample_t data_pt
);

   localparam int PW = ptr_width(DEPTH);
   typedef logic [PW-1:0] ptr_t;

   logic [DEPTH-1:0] mem;
   ptr_t             wptr;
   ptr_t             rptr;
   logic             wr_acc;
   logic             rd_acc;
   logic             rd_bit;

   assign bEmpty = (wptr == rptr);
   assign bFull  = (wptr[PW-1] != rptr[PW-1]) && (wptr[PW-2:0] == rptr[PW-2:0]);
   assign dFLAG  = ~bEmpty;

   // Acceptance uses the pre-edge flags, so a full FIFO still reads and an
   // empty FIFO still writes when both requests arrive together.
   assign wr_acc = wEN & ~bFull;
   assign rd_acc = rEN & ~bEmpty;
   assign rd_bit = mem[rptr[PW-2:0]];

   // Store the incoming bit at the write index.
   // NOTE: storage has no reset; stale bits are unreachable once the pointers clear.
   always_ff @(posedge CLK) begin
      if (wr_acc) begin
         mem[wptr[PW-2:0]] <= dIn;
      end
   end

   // Advance the write/read pointers, modulo twice the depth.
   // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge CLK) begin
      if (RST) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (wr_acc) wptr <= wptr + ptr_t'(1);
         if (rd_acc) rptr <= rptr + ptr_t'(1);
      end
   end

   // Register the bit popped by an accepted read; hold it otherwise.
   always_ff @(posedge CLK) begin
      if (RST) begin
         dOut <= 1'b0;
      end else if (rd_acc) begin
         dOut <= rd_bit;
      end
   end

`ifdef SYN_FIFO_MAPPER_EN
   bpsk_mapper #(
      .AMP (AMP)
   ) u_mapper (
      .clk      (CLK),
      .rst      (RST),
      .load     (rd_acc),
      .data_bit (rd_bit),
      .point    (data_pt)
   );
`else
   // Mapper stripped: the point is zero whatever AMP is set to.
   assign data_pt = sample_t'(AMP) & '0;
`endif

endmodule

// File: tb/tb_syn_fifo.sv
// Self-checking bench for syn_fifo. A queue-based model of the FIFO plus the
// BPSK mapping rule predicts flags, dOut and data_pt after every clock.
// Expected data_pt follows SYN_FIFO_MAPPER_EN the same way the build does.
module tb_syn_fifo;
   import syn_fifo_pkg::*;

   localparam int DEPTH = DEFAULT_DEPTH;
`ifdef SYN_FIFO_MAPPER_EN
   localparam sample_t MAG = sample_t'(DEFAULT_AMP);
`else
   localparam sample_t MAG = sample_t'(0);
`endif
   localparam sample_t EXP_P = MAG;
   localparam sample_t EXP_N = -MAG;

   logic    CLK = 1'b0;
   logic    RST = 1'b0;
   logic    wEN = 1'b0;
   logic    rEN = 1'b0;
   logic    dIn = 1'b0;
   logic    bFull, bEmpty, dOut, dFLAG;
   sample_t data_pt;

   int checks = 0;
   int errors = 0;

   // Reference model state
   bit      q[$];
   logic    exp_dout = 1'b0;
   sample_t exp_pt   = '0;

   syn_fifo dut (
      .CLK     (CLK),
      .RST     (RST),
      .wEN     (wEN),
      .rEN     (rEN),
      .dIn     (dIn),
      .bFull   (bFull),
      .bEmpty  (bEmpty),
      .dOut    (dOut),
      .dFLAG   (dFLAG),
      .data_pt (data_pt)
   );

   always #5 CLK = ~CLK;

   function automatic sample_t pt_of(input logic b);
      return b ? EXP_P : EXP_N;
   endfunction

   // {bFull, bEmpty, dFLAG, dOut, data_pt} as the model predicts it
   function automatic logic [19:0] exp_vec();
      logic full, empty;
      full  = (q.size() == DEPTH);
      empty = (q.size() == 0);
      return {full, empty, ~empty, exp_dout, exp_pt};
   endfunction

   // Drive one cycle of requests and advance the model at the same edge.
   task automatic step(input logic rst, input logic w, input logic r, input logic d);
      logic full, empty;
      @(negedge CLK);
      RST = rst; wEN = w; rEN = r; dIn = d;
      @(posedge CLK);
      full  = (q.size() == DEPTH);
      empty = (q.size() == 0);
      if (rst) begin
         q.delete();
         exp_dout = 1'b0;
         exp_pt   = '0;
      end else begin
         if (r && !empty) begin
            exp_dout = q.pop_front();
            exp_pt   = pt_of(exp_dout);
         end
         if (w && !full) q.push_back(d);
      end
      #1;
   endtask

   task automatic test_reset();
      step(1'b1, 1'b0, 1'b0, 1'b0);
      checks++; if (bEmpty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", bEmpty); end
      checks++; if (bFull !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", bFull); end
      checks++; if (dFLAG !== 1'b0) begin errors++; $display("FAIL reset_flag: got %b expected 0", dFLAG); end
      checks++; if (dOut !== 1'b0) begin errors++; $display("FAIL reset_dout: got %b expected 0", dOut); end
      checks++; if (data_pt !== 16'h0000) begin errors++; $display("FAIL reset_pt: got %h expected 0000", data_pt); end
      // Reset wins over a simultaneous write request.
      step(1'b1, 1'b1, 1'b0, 1'b1);
      checks++; if (bEmpty !== 1'b1) begin errors++; $display("FAIL reset_override: got bEmpty %b expected 1", bEmpty); end
      step(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_fill_drain();
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b0, 1'b1, 1'b0, logic'(i % 2));
         checks++; if ({bFull, bEmpty, dFLAG, dOut, data_pt} !== exp_vec())
            begin errors++; $display("FAIL fill_status[%0d]: got %h expected %h", i, {bFull, bEmpty, dFLAG, dOut, data_pt}, exp_vec()); end
      end
      checks++; if (bFull !== 1'b1) begin errors++; $display("FAIL fill_full: got %b expected 1", bFull); end
      for (int i = 0; i < DEPTH; i++) begin
         checks++;
         if (dFLAG !== 1'b1) begin
            errors++; $display("FAIL drain_gate[%0d]: got dFLAG %b expected 1", i, dFLAG);
            break;
         end
         step(1'b0, 1'b0, 1'b1, 1'b0);
         checks++; if (dOut !== logic'(i % 2)) begin errors++; $display("FAIL drain_dout[%0d]: got %b expected %0d", i, dOut, i % 2); end
         checks++; if (data_pt !== ((i % 2 == 1) ? EXP_P : EXP_N))
            begin errors++; $display("FAIL drain_pt[%0d]: got %h expected %h", i, data_pt, (i % 2 == 1) ? EXP_P : EXP_N); end
      end
      checks++; if ({bEmpty, dFLAG} !== 2'b10) begin errors++; $display("FAIL drain_empty: got bEmpty/dFLAG %b expected 10", {bEmpty, dFLAG}); end
   endtask

   task automatic test_overflow_underflow();
      logic [DEPTH-1:0] pat;
      pat = DEPTH'($urandom);
      for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, pat[i]);
      step(1'b0, 1'b1, 1'b0, ~pat[0]);   // ignored: FIFO full
      checks++; if ({bFull, bEmpty, dFLAG, dOut, data_pt} !== exp_vec())
         begin errors++; $display("FAIL overflow_status: got %h expected %h", {bFull, bEmpty, dFLAG, dOut, data_pt}, exp_vec()); end
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b0, 1'b0, 1'b1, 1'b0);
         checks++; if (dOut !== pat[i]) begin errors++; $display("FAIL overflow_dout[%0d]: got %b expected %b", i, dOut, pat[i]); end
      end
      for (int i = 0; i < 2; i++) begin
         step(1'b0, 1'b0, 1'b1, 1'b0);   // ignored: FIFO empty
         checks++; if ({dOut, data_pt} !== {pat[DEPTH-1], pt_of(pat[DEPTH-1])})
            begin errors++; $display("FAIL underflow_hold[%0d]: got %h expected %h", i, {dOut, data_pt}, {pat[DEPTH-1], pt_of(pat[DEPTH-1])}); end
      end
   endtask

   task automatic test_simultaneous();
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, logic'($urandom_range(0, 1)));
      step(1'b0, 1'b1, 1'b1, logic'($urandom_range(0, 1)));
      checks++; if ({bFull, bEmpty, dFLAG, dOut, data_pt} !== exp_vec())
         begin errors++; $display("FAIL simul_mid: got %h expected %h", {bFull, bEmpty, dFLAG, dOut, data_pt}, exp_vec()); end
      // Occupancy must still be three: two reads leave data, the third empties it.
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 1'b1, 1'b0);
         checks++; if ({bFull, bEmpty, dFLAG, dOut, data_pt} !== exp_vec())
            begin errors++; $display("FAIL simul_drain[%0d]: got %h expected %h", i, {bFull, bEmpty, dFLAG, dOut, data_pt}, exp_vec()); end
      end
      step(1'b0, 1'b1, 1'b1, 1'b1);   // empty: write only
      checks++; if (dFLAG !== 1'b1) begin errors++; $display("FAIL simul_empty_flag: got %b expected 1", dFLAG); end
      checks++; if ({bFull, bEmpty, dFLAG, dOut, data_pt} !== exp_vec())
         begin errors++; $display("FAIL simul_empty: got %h expected %h", {bFull, bEmpty, dFLAG, dOut, data_pt}, exp_vec()); end
      while (q.size() < DEPTH) step(1'b0, 1'b1, 1'b0, logic'($urandom_range(0, 1)));
      step(1'b0, 1'b1, 1'b1, 1'b0);   // full: read only
      checks++; if (bFull !== 1'b0) begin errors++; $display("FAIL simul_full_flag: got %b expected 0", bFull); end
      checks++; if ({bFull, bEmpty, dFLAG, dOut, data_pt} !== exp_vec())
         begin errors++; $display("FAIL simul_full: got %h expected %h", {bFull, bEmpty, dFLAG, dOut, data_pt}, exp_vec()); end
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b0, 1'b0, 1'b1, 1'b0);
         checks++; if ({bFull, bEmpty, dFLAG, dOut, data_pt} !== exp_vec())
            begin errors++; $display("FAIL simul_flush[%0d]: got %h expected %h", i, {bFull, bEmpty, dFLAG, dOut, data_pt}, exp_vec()); end
      end
   endtask

   task automatic test_wrap();
      logic b;
      for (int i = 0; i < 20; i++) begin
         b = (i % 4 != 2);
         step(1'b0, 1'b1, 1'b0, b);
         checks++; if ({bFull, bEmpty, dFLAG, dOut, data_pt} !== exp_vec())
            begin errors++; $display("FAIL wrap_wr[%0d]: got %h expected %h", i, {bFull, bEmpty, dFLAG, dOut, data_pt}, exp_vec()); end
         step(1'b0, 1'b0, 1'b1, 1'b0);
         checks++; if ({bEmpty, dFLAG, dOut, data_pt} !== {2'b10, b, pt_of(b)})
            begin errors++; $display("FAIL wrap_rd[%0d]: got %h expected %h", i, {bEmpty, dFLAG, dOut, data_pt}, {2'b10, b, pt_of(b)}); end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         step(1'b0, logic'($urandom_range(0, 99) < 55), logic'($urandom_range(0, 99) < 45), logic'($urandom_range(0, 1)));
         checks++; if ({bFull, bEmpty, dFLAG, dOut, data_pt} !== exp_vec())
            begin errors++; $display("FAIL random[%0d]: got %h expected %h", i, {bFull, bEmpty, dFLAG, dOut, data_pt}, exp_vec()); end
      end
   endtask

   task automatic test_mid_reset();
      step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0);   // leaves a nonzero point before the reset
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, logic'($urandom_range(0, 1)));
      step(1'b1, 1'b0, 1'b0, 1'b0);
      checks++; if ({bEmpty, dFLAG} !== 2'b10) begin errors++; $display("FAIL midrst_flags: got %b expected 10", {bEmpty, dFLAG}); end
      checks++; if (data_pt !== 16'h0000) begin errors++; $display("FAIL midrst_pt: got %h expected 0000", data_pt); end
      step(1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      checks++; if (dOut !== 1'b1) begin errors++; $display("FAIL midrst_dout: got %b expected 1", dOut); end
      checks++; if (data_pt !== EXP_P) begin errors++; $display("FAIL midrst_newpt: got %h expected %h", data_pt, EXP_P); end
      checks++; if (bEmpty !== 1'b1) begin errors++; $display("FAIL midrst_empty: got %b expected 1", bEmpty); end
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_overflow_underflow();
      test_simultaneous();
      test_wrap();
      test_random();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
